// File: rtl/ffs_issue_scheduler.sv
// Round-robin issue scheduler that shares one fixed-latency find-first-set engine among NREQ requesters.
// Optional FFS_SCHED_ZERO_FLAG_EN: carries an all-zero flag with each request and reports it on rsp_zero.
module ffs_issue_scheduler #(
  parameter int NREQ       = 4,
  parameter int W          = 1024,
  parameter int IDX_W      = 10,
  parameter int ENG_LAT    = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     eng_valid,
  output logic [W-1:0]             eng_data,
  input  logic [IDX_W-1:0]         eng_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDX_W-1:0]         rsp_index,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     rsp_zero
);

  localparam int ID_W  = $clog2(NREQ);
  // Tag stage 0 sits beside eng_valid; the last stage lines up with a valid eng_result.
  localparam int LINE  = ENG_LAT + 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]            rr_ptr;
  logic [ID_W-1:0]            grant_idx;
  logic [ID_W:0]              cand;
  logic                       found;
  logic                       credit_ok;
  logic                       accept;
  logic [W-1:0]               sel_data;
  logic [LINE-1:0]            tag_vld;
  logic [LINE-1:0][ID_W-1:0]  tag_id;
  logic [CNT_W-1:0]           fifo_count;
  logic [CNT_W-1:0]           inflight;
  logic [CNT_W:0]             occupancy;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [IDX_W-1:0]           mem_idx [FIFO_DEPTH];
  logic [ID_W-1:0]            mem_id  [FIFO_DEPTH];
  logic                       wr_en;
  logic                       pop;
  logic [IDX_W-1:0]           wr_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(off);
      if (cand >= (ID_W+1)'(NREQ)) cand = cand - (ID_W+1)'(NREQ);
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

  // Credit covers every accepted request not yet popped, so the FIFO can never overflow.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
  assign credit_ok = occupancy < (CNT_W+1)'(FIFO_DEPTH);
  assign accept    = found & credit_ok;
  assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;
  assign sel_data  = req_data[int'(grant_idx)*W +: W];

  assign wr_en     = tag_vld[LINE-1];
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_index = mem_idx[rd_ptr];
  assign rsp_id    = mem_id[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= ID_W'(NREQ - 1);
      eng_valid  <= 1'b0;
      eng_data   <= '0;
      tag_vld    <= '0;
      tag_id     <= '0;
      fifo_count <= '0;
      inflight   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_idx[i] <= '0;
        mem_id[i]  <= '0;
      end
    end else begin
      eng_valid <= accept;
      tag_vld   <= {tag_vld[LINE-2:0], accept};
      tag_id    <= {tag_id[LINE-2:0], grant_idx};
      if (accept) begin
        rr_ptr   <= grant_idx;
        eng_data <= sel_data;
      end
      if (wr_en) begin
        mem_idx[wr_ptr] <= wr_idx;
        mem_id[wr_ptr]  <= tag_id[LINE-1];
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + CNT_W'(wr_en) - CNT_W'(pop);
      inflight   <= inflight + CNT_W'(accept) - CNT_W'(wr_en);
    end
  end

`ifdef FFS_SCHED_ZERO_FLAG_EN
  logic [LINE-1:0] tag_zero;
  logic            mem_zero [FIFO_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_zero <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_zero[i] <= 1'b0;
    end else begin
      tag_zero <= {tag_zero[LINE-2:0], ~|sel_data};
      if (wr_en) mem_zero[wr_ptr] <= tag_zero[LINE-1];
    end
  end

  assign wr_idx   = tag_zero[LINE-1] ? '0 : eng_result;
  assign rsp_zero = mem_zero[rd_ptr];
`else
  assign wr_idx   = eng_result;
  assign rsp_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) assert (occupancy <= (CNT_W+1)'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_ffs_issue_scheduler.sv
// Randomized bench for ffs_issue_scheduler: behavioural engine plus a queue-based response model.
module tb_ffs_issue_scheduler;
  localparam int NREQ       = 4;
  localparam int W          = 1024;
  localparam int IDX_W      = 10;
  localparam int ENG_LAT    = 10;
  localparam int FIFO_DEPTH = 16;
  localparam int ID_W       = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*W-1:0]   req_data;
  logic [NREQ-1:0]     req_ready;
  logic                eng_valid;
  logic [W-1:0]        eng_data;
  logic [IDX_W-1:0]    eng_result;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDX_W-1:0]    rsp_index;
  logic [ID_W-1:0]     rsp_id;
  logic                rsp_zero;

  always #5 clk = ~clk;

  ffs_issue_scheduler #(
    .NREQ(NREQ), .W(W), .IDX_W(IDX_W), .ENG_LAT(ENG_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .eng_valid(eng_valid), .eng_data(eng_data), .eng_result(eng_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_index(rsp_index), .rsp_id(rsp_id), .rsp_zero(rsp_zero)
  );

  // Lowest set bit; an all-zero vector yields all ones so it is distinguishable.
  function automatic logic [IDX_W-1:0] ffs(input logic [W-1:0] v);
    logic [IDX_W-1:0] r = '1;
    for (int i = W-1; i >= 0; i--) if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  // Engine: sampled at edge S, result presented from edge S+ENG_LAT.
  logic [IDX_W-1:0] eng_pipe [ENG_LAT];
  always @(posedge clk) begin
    eng_pipe[0] <= ffs(eng_data);
    for (int k = 1; k < ENG_LAT; k++) eng_pipe[k] <= eng_pipe[k-1];
    eng_result <= eng_pipe[ENG_LAT-1];
  end

  typedef struct {
    int               id;
    logic [IDX_W-1:0] idx;
    logic             zero;
    int               due;
  } rsp_t;

  rsp_t            q[$];
  int              rr, occ, edge_n;
  int              checks = 0, failures = 0;
  int              n_acc, dut_acc;
  logic            exp_eng_valid;
  logic [W-1:0]    exp_eng_data;
  logic [NREQ-1:0] mask;
  int              valid_pct, ready_pct;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 1; k <= NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic rsp_t mk_rsp(input int id, input logic [W-1:0] v, input int due);
    rsp_t r;
    r.id  = id;
    r.due = due;
`ifdef FFS_SCHED_ZERO_FLAG_EN
    r.zero = (v == '0);
    r.idx  = r.zero ? '0 : ffs(v);
`else
    r.zero = 1'b0;
    r.idx  = ffs(v);
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v = '0;
    int k = $urandom_range(0, 7);
    for (int j = 0; j < k; j++) v[$urandom_range(0, W-1)] = 1'b1;
    return v;
  endfunction

  function automatic int queued();
    int n = 0;
    foreach (q[i]) if (q[i].due <= edge_n) n++;
    return n;
  endfunction

  task automatic cycle();
    logic [NREQ-1:0] exp_ready;
    logic            exp_rv, pop;
    int              g;
    @(negedge clk);
    g = rr_pick(req_valid, rr);
    exp_ready = '0;
    if (g >= 0 && occ < FIFO_DEPTH) exp_ready[g] = 1'b1;
    check("req_ready", W'(req_ready), W'(exp_ready));
    if ((req_valid & req_ready) != '0) dut_acc++;
    check("eng_valid", W'(eng_valid), W'(exp_eng_valid));
    if (exp_eng_valid) check("eng_data", eng_data, exp_eng_data);
    exp_rv = (q.size() > 0) && (q[0].due <= edge_n);
    check("rsp_valid", W'(rsp_valid), W'(exp_rv));
    if (exp_rv) begin
      check("rsp_index", W'(rsp_index), W'(q[0].idx));
      check("rsp_id", W'(rsp_id), W'(q[0].id));
      check("rsp_zero", W'(rsp_zero), W'(q[0].zero));
    end
    pop = exp_rv && rsp_ready;
    @(posedge clk);
    edge_n++;
    exp_eng_valid = 1'b0;
    if (exp_ready != '0) begin
      q.push_back(mk_rsp(g, req_data[g*W +: W], edge_n + ENG_LAT + 2));
      rr = g;
      occ++;
      n_acc++;
      exp_eng_valid = 1'b1;
      exp_eng_data  = req_data[g*W +: W];
    end
    if (pop) begin
      void'(q.pop_front());
      occ--;
    end
    #1;
    if (exp_ready != '0) req_valid[g] = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (!req_valid[i] && mask[i] && $urandom_range(0, 99) < valid_pct) begin
        req_valid[i] = 1'b1;
        req_data[i*W +: W] = rand_vec();
      end
    rsp_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    #1;
    check("rst_rsp_valid", W'(rsp_valid), W'(0));
    check("rst_eng_valid", W'(eng_valid), W'(0));
    check("rst_eng_data", eng_data, '0);
    check("rst_req_ready", W'(req_ready), W'(0));
    check("rst_rsp_index", W'(rsp_index), W'(0));
    check("rst_rsp_id", W'(rsp_id), W'(0));
    check("rst_rsp_zero", W'(rsp_zero), W'(0));
    q.delete();
    occ = 0;
    rr = NREQ - 1;
    exp_eng_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain();
    mask = '0;
    req_valid = '0;
    ready_pct = 100;
    rsp_ready = 1'b1;
    for (int i = 0; i < 200 && q.size() > 0; i++) cycle();
    cycle();
    check("drained", W'(rsp_valid), W'(0));
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    mask = '0; valid_pct = 0; ready_pct = 100;
    rr = NREQ - 1; occ = 0; edge_n = 0; n_acc = 0; dut_acc = 0; exp_eng_valid = 1'b0;
    do_reset();

    // single request, bit 37
    req_data[37] = 1'b1;
    req_valid[0] = 1'b1;
    repeat (16) cycle();

    // all requesters saturating, consumer always ready
    mask = '1; valid_pct = 100; ready_pct = 100;
    repeat (30) cycle();
    dut_acc = 0;
    repeat (30) cycle();
    check("tput_open", W'(dut_acc), W'(30));
    drain();

    // consumer stalled, requester 2 streams until credit runs out
    mask = 4'b0100; valid_pct = 100; ready_pct = 0; rsp_ready = 1'b0;
    dut_acc = 0;
    repeat (40) cycle();
    check("stream_accepts", W'(dut_acc), W'(FIFO_DEPTH));
    drain();

    // start at the credit limit, then release the consumer
    mask = '1; valid_pct = 100; ready_pct = 0; rsp_ready = 1'b0;
    repeat (30) cycle();
    ready_pct = 100; rsp_ready = 1'b1;
    repeat (20) cycle();
    dut_acc = 0;
    repeat (30) cycle();
    check("tput_limit", W'(dut_acc), W'(30));

    // random traffic and backpressure
    valid_pct = 60; ready_pct = 70;
    repeat (400) cycle();
    ready_pct = 30;
    repeat (200) cycle();
    drain();

    // reset with results both in flight and queued
    mask = 4'b0010; valid_pct = 100; ready_pct = 0; rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 20 && n_acc < 8; i++) cycle();
    mask = '0; req_valid = '0;
    for (int i = 0; i < 40 && queued() < 3; i++) cycle();
    check("pre_reset_queued", W'(rsp_valid), W'(1));
    do_reset();
    ready_pct = 100; rsp_ready = 1'b1;
    repeat (20) cycle();
    mask = '1; valid_pct = 100;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = 1'b1;
      req_data[i*W +: W] = rand_vec();
    end
    repeat (8) cycle();
    drain();

    // all-zero input vector
    req_data[3*W +: W] = '0;
    req_valid[3] = 1'b1;
    repeat (16) cycle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
